mux_stream_nway: RTL
====================

# mux_stream_nway

Registered N-way, N-bit stream multiplexer with valid/ready handshaking: the pipelined, multi-channel successor to the 2:1 combinational N-bit mux. It selects one of M input channels, either by an explicit select or by round-robin arbitration, and captures the chosen beat into a single output register. It sits between multiple producers (register-file read ports, functional-unit result buses) and one consumer that may stall.

## Interface
- N, default 32: data width per channel, 1..64.
- M, default 4: channel count, 2..8.
- S, derived, not overridable: select width, clog2(M).

- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  M*N  channel i occupies bits [i*N +: N].
- in_valid  input  M  per-channel valid.
- in_ready  output  M  per-channel ready; at most one bit set.
- sel  input  S  explicit channel select; used only in fixed mode.
- out_data  output  N  registered selected data.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  consumer accepts the beat.
- out_chan  output  S  source channel of the held beat.

## Operation
- Clocking and reset: one clock; reset is synchronous and active-high.
- Register state: out_data, out_valid, out_chan, plus rr_ptr (S bits) in round-robin mode.
- `can_accept = !out_valid || out_ready`.
- Grant g: channel chosen this cycle, per mode.
  - Fixed mode: g = sel. If sel >= M or in_valid[sel] = 0, there is no grant.
  - Round-robin mode: g is the first i with in_valid[i] = 1, searching rr_ptr, rr_ptr+1, … mod M. If no bit of in_valid is set, there is no grant.
- `in_ready[i] = can_accept && grant && (i == g)`. This is combinational from in_valid, sel, out_valid and out_ready. A channel's ready never depends on its own valid except through arbitration.
- Transfer on channel g: in_valid[g] && in_ready[g].
- On a transfer at a clock edge: out_data <= in_data[g], out_chan <= g, out_valid <= 1. In round-robin mode, also rr_ptr <= (g+1) mod M, wrapping from M-1 to 0.
- Output drained with no new transfer (out_valid && out_ready && no grant): out_valid <= 0. out_data and out_chan keep their last value.
- Stall (out_valid && !out_ready): out_data, out_chan and out_valid hold. All in_ready bits = 0.
- Drain and refill in the same cycle: the new beat replaces the old one, and out_valid stays 1 with no bubble.
- rr_ptr changes only on a transfer. Idle cycles and stalls do not advance it.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_chan = 0, rr_ptr = 0. While rst = 1, in_ready = 0.
- Latency: a beat accepted at edge k appears with out_valid = 1 after edge k, i.e. one cycle.
- Throughput: one beat per cycle while out_ready = 1.
- Reset asserted mid-operation: a held beat is discarded. The first transfer is possible in the cycle after rst deasserts.
- Fairness: with all M channels continuously valid and out_ready = 1, grants cycle 0, 1, …, M-1, 0, … A channel waits at most M-1 transfers.
- sel changing while stalled has no effect until can_accept = 1.

## Configuration
- MUX_STREAM_RR_EN:
  - Defined: round-robin arbitration as above. The sel port exists but is ignored.
  - Undefined: fixed mode, grant = sel. The rr_ptr register is not instantiated.

## Test plan
- Reset: rst = 1 for 2 cycles with all in_valid = 1 → out_valid = 0, out_data = 0, out_chan = 0, in_ready = 0.
- Fixed mode, N = 16, M = 4: sel = 2, in_data ch2 = 16'hA5A5, in_valid = 4'b0100, out_ready = 1 → in_ready = 4'b0100; next cycle out_data = 16'hA5A5, out_chan = 2. Then sel = 3 with in_valid[3] = 0 → in_ready = 0, and out_valid drops to 0.
- Round-robin, M = 4: in_valid = 4'b1111 for 6 cycles with out_ready = 1 → out_chan sequence 0, 1, 2, 3, 0, 1 with no bubbles.
- Round-robin wrap and skip: rr_ptr = 3, in_valid = 4'b0011 → grant ch0, and rr_ptr becomes 1.
- Backpressure, N = 32: out_valid = 1 with out_data = 32'h12345678, out_ready = 0 for 3 cycles while in_valid = 4'b1111 → out_data is held and in_ready = 0. When out_ready returns to 1, the beat is replaced in the same cycle.
- Mid-operation reset: out_valid = 1, out_ready = 0, then rst = 1 for 1 cycle → out_valid = 0 and rr_ptr = 0, and the first grant after reset goes to ch0.

Source files
------------

// File: rtl/mux_stream_nway.sv
// mux_stream_nway: registered M-way, N-bit stream mux with valid/ready handshake.
// Define MUX_STREAM_RR_EN for round-robin arbitration; otherwise sel_i picks the channel.
module mux_stream_nway #(
  parameter int N = 32,
  parameter int M = 4,
  localparam int S = $clog2(M)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [M*N-1:0] in_data_i,
  input  logic [M-1:0]   in_valid_i,
  output logic [M-1:0]   in_ready_o,
  input  logic [S-1:0]   sel_i,
  output logic [N-1:0]   out_data_o,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [S-1:0]   out_chan_o
);

  logic [N-1:0] data_q, data_d;
  logic         valid_q, valid_d;
  logic [S-1:0] chan_q, chan_d;
  logic         grant_vld;
  logic [S-1:0] grant_idx;
  logic [N-1:0] grant_data;
  logic         can_accept;
  logic         xfer;

`ifdef MUX_STREAM_RR_EN
  logic [S-1:0] rr_q, rr_d;
  logic         unused_sel;

  assign unused_sel = ^sel_i;

  // Search order rr_q, rr_q+1, ... folded back into 0..M-1.
  always_comb begin
    int pos;
    pos       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < M; k++) begin
      pos = int'(rr_q) + k;
      if (pos >= M) pos = pos - M;
      for (int i = 0; i < M; i++) begin
        if (!grant_vld && (pos == i) && in_valid_i[i]) begin
          grant_vld = 1'b1;
          grant_idx = S'(i);
        end
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (xfer) rr_d = (grant_idx == S'(M - 1)) ? '0 : grant_idx + S'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rr_q <= '0;
    else       rr_q <= rr_d;
  end
`else
  // Out-of-range selects simply match no channel.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < M; i++) begin
      if ((sel_i == S'(i)) && in_valid_i[i]) begin
        grant_vld = 1'b1;
        grant_idx = S'(i);
      end
    end
  end
`endif

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < M; i++) begin
      if (grant_idx == S'(i)) grant_data = in_data_i[i*N +: N];
    end
  end

  assign can_accept = !valid_q || out_ready_i;
  assign in_ready_o = (!rst_i && can_accept && grant_vld) ? (M'(1) << grant_idx) : '0;
  assign xfer       = |in_ready_o;

  always_comb begin
    data_d  = data_q;
    chan_d  = chan_q;
    valid_d = valid_q;
    if (xfer) begin
      data_d  = grant_data;
      chan_d  = grant_idx;
      valid_d = 1'b1;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
    end
  end

  assign out_data_o  = data_q;
  assign out_chan_o  = chan_q;
  assign out_valid_o = valid_q;

endmodule
